mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM
//
// Sequences a multi-cycle datapath through fetch, decode, address,
// memory, execute and write-back steps for addu, subu, jr, ori, lui,
// lw, sw, beq and j. Anything else raises a one-cycle illegal pulse
// in DECODE and returns to FETCH.
//
// Optional feature: define MC_CTRL_PERF_EN to build the cycle and
// instruction counters. Without it both counter ports read zero.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous active-high reset
//   opcode     IR[31:26], stable between IRWr pulses
//   funct      IR[5:0]
//   zero       ALU equality flag (A == B)
//   ALUop      00 add, 01 sub, 10 or
//   PCWr       PC write enable
//   IRWr       IR write enable
//   RegWr      register file write enable
//   MemWr      data memory write enable
//   RegDst     0 = rt, 1 = rd
//   MemtoReg   0 = ALU result, 1 = memory data
//   ALUSrcB    0 = register B, 1 = extended immediate
//   ExtOp      00 zero-ext, 01 sign-ext, 10 imm<<16
//   NPCsel     00 PC+4, 01 branch, 10 jump, 11 rs
//   illegal    unsupported-instruction pulse (DECODE only)
//   state      current FSM state, debug
//   cycle_cnt  non-reset cycles seen (MC_CTRL_PERF_EN)
//   instr_cnt  completed instructions (MC_CTRL_PERF_EN)

module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [1:0]  ALUop,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcB,
    output logic [1:0]  ExtOp,
    output logic [1:0]  NPCsel,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MA     = 4'd2,
        MR     = 4'd3,
        MW     = 4'd4,
        MWB    = 4'd5,
        EXE    = 4'd6,
        RWB    = 4'd7,
        IWB    = 4'd8,
        BR     = 4'd9,
        JMP    = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    state_t cur_state;
    state_t next_state;

    logic is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
    logic is_rtype, is_legal;

    // Instruction decode from the held IR fields.
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_addu  = is_rtype && (funct == FN_ADDU);
        is_subu  = is_rtype && (funct == FN_SUBU);
        is_jr    = is_rtype && (funct == FN_JR);
        is_ori   = (opcode == OP_ORI);
        is_lui   = (opcode == OP_LUI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_j;
    end

    // Next-state logic. Encodings 11-15 fall to the default and
    // recover to FETCH on the next edge.
    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (is_lw || is_sw)
                    next_state = MA;
                else if (is_addu || is_subu || is_ori || is_lui)
                    next_state = EXE;
                else if (is_beq)
                    next_state = BR;
                else if (is_j || is_jr)
                    next_state = JMP;
                else
                    next_state = FETCH;
            end
            MA:     next_state = is_lw ? MR : MW;
            MR:     next_state = MWB;
            EXE:    next_state = is_rtype ? RWB : IWB;
            MW, MWB, RWB, IWB, BR, JMP:
                    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur_state <= FETCH;
        else
            cur_state <= next_state;
    end

    assign state = cur_state;

    // Control outputs: Moore on state, qualified by the instruction
    // for the EXE/write-back and jump steps.
    always_comb begin
        ALUop    = ALU_ADD;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcB  = 1'b0;
        ExtOp    = EXT_ZERO;
        NPCsel   = NPC_SEQ;
        illegal  = 1'b0;

        case (cur_state)
            FETCH: begin
                PCWr   = 1'b1;
                IRWr   = 1'b1;
                NPCsel = NPC_SEQ;
            end
            DECODE: begin
                illegal = ~is_legal;
            end
            MA, MR, MW: begin
                ALUop   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtOp   = EXT_SIGN;
                MemWr   = (cur_state == MW);
            end
            MWB: begin
                RegWr    = 1'b1;
                RegDst   = 1'b0;
                MemtoReg = 1'b1;
            end
            EXE, RWB, IWB: begin
                // ALU controls stay stable through write-back so the
                // result being written is the one just computed.
                if (is_subu) begin
                    ALUop = ALU_SUB;
                end else if (is_ori) begin
                    ALUop   = ALU_OR;
                    ALUSrcB = 1'b1;
                    ExtOp   = EXT_ZERO;
                end else if (is_lui) begin
                    ALUop   = ALU_ADD;
                    ALUSrcB = 1'b1;
                    ExtOp   = EXT_LUI;
                end else begin
                    ALUop = ALU_ADD;
                end
                if (cur_state == RWB) begin
                    RegWr  = 1'b1;
                    RegDst = 1'b1;
                end else if (cur_state == IWB) begin
                    RegWr  = 1'b1;
                    RegDst = 1'b0;
                end
            end
            BR: begin
                ALUop  = ALU_SUB;
                ExtOp  = EXT_SIGN;
                NPCsel = NPC_BR;
                PCWr   = zero;
            end
            JMP: begin
                PCWr   = 1'b1;
                NPCsel = is_jr ? NPC_JR : NPC_J;
            end
            default: begin
                // Unused encodings: everything stays at its default.
            end
        endcase

        // Reset kills all write enables at once, so an instruction
        // interrupted mid-flight cannot complete its write.
        if (reset) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RegWr   = 1'b0;
            MemWr   = 1'b0;
            illegal = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic completing;

    // An instruction retires when a terminal step hands back to FETCH.
    // The illegal DECODE->FETCH path and recovery from unused
    // encodings are deliberately not counted.
    assign completing = (next_state == FETCH) &&
                        (cur_state inside {MW, MWB, RWB, IWB, BR, JMP});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (completing)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl

module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [1:0]  ALUop;
    logic        PCWr;
    logic        IRWr;
    logic        RegWr;
    logic        MemWr;
    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrcB;
    logic [1:0]  ExtOp;
    logic [1:0]  NPCsel;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    int n_assert;
    int n_fail;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .ALUop     (ALUop),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ALUSrcB   (ALUSrcB),
        .ExtOp     (ExtOp),
        .NPCsel    (NPCsel),
        .illegal   (illegal),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;

        // Reset held across edges
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pcwr", 32'(PCWr), 32'd0);
        check("rst_irwr", 32'(IRWr), 32'd0);
        tick();
        check("rst_state2", 32'(state), 32'd0);
        check("rst_cyc", cycle_cnt, 32'd0);
        check("rst_ins", instr_cnt, 32'd0);

        // Release at negedge, program ori / j / lw
        @(negedge clk);
        reset  = 1'b0;
        opcode = 6'b001101;
        #1;
        check("f0_irwr", 32'(IRWr), 32'd1);
        check("f0_pcwr", 32'(PCWr), 32'd1);
        check("f0_npc", 32'(NPCsel), 32'd0);

        // ori
        tick();
        check("ori_dec_st", 32'(state), 32'd1);
        check("ori_dec_ill", 32'(illegal), 32'd0);
        tick();
        check("ori_exe_st", 32'(state), 32'd6);
        check("ori_exe_alu", 32'(ALUop), 32'd2);
        check("ori_exe_srcb", 32'(ALUSrcB), 32'd1);
        check("ori_exe_ext", 32'(ExtOp), 32'd0);
        tick();
        check("ori_iwb_st", 32'(state), 32'd8);
        check("ori_iwb_regwr", 32'(RegWr), 32'd1);
        check("ori_iwb_dst", 32'(RegDst), 32'd0);
        check("ori_iwb_alu", 32'(ALUop), 32'd2);
        tick();
        check("ori_fetch", 32'(state), 32'd0);

        // j
        opcode = 6'b000010;
        tick();
        check("j_dec_st", 32'(state), 32'd1);
        tick();
        check("j_jmp_st", 32'(state), 32'd10);
        check("j_pcwr", 32'(PCWr), 32'd1);
        check("j_npc", 32'(NPCsel), 32'd2);
        tick();
        check("j_fetch", 32'(state), 32'd0);

        // lw
        opcode = 6'b100011;
        tick();
        check("lw_dec_st", 32'(state), 32'd1);
        check("lw_dec_memwr", 32'(MemWr), 32'd0);
        tick();
        check("lw_ma_st", 32'(state), 32'd2);
        check("lw_ma_srcb", 32'(ALUSrcB), 32'd1);
        check("lw_ma_ext", 32'(ExtOp), 32'd1);
        check("lw_ma_memwr", 32'(MemWr), 32'd0);
        tick();
        check("lw_mr_st", 32'(state), 32'd3);
        check("lw_mr_memwr", 32'(MemWr), 32'd0);
        tick();
        check("lw_mwb_st", 32'(state), 32'd5);
        check("lw_mwb_regwr", 32'(RegWr), 32'd1);
        check("lw_mwb_m2r", 32'(MemtoReg), 32'd1);
        check("lw_mwb_dst", 32'(RegDst), 32'd0);
        check("lw_mwb_memwr", 32'(MemWr), 32'd0);
        tick();
        check("lw_fetch", 32'(state), 32'd0);
`ifdef MC_CTRL_PERF_EN
        check("perf_cyc", cycle_cnt, 32'd12);
        check("perf_ins", instr_cnt, 32'd3);
`else
        check("noperf_cyc", cycle_cnt, 32'd0);
        check("noperf_ins", instr_cnt, 32'd0);
`endif

        // beq taken
        opcode = 6'b000100;
        zero   = 1'b1;
        tick();
        check("beq1_dec", 32'(state), 32'd1);
        tick();
        check("beq1_st", 32'(state), 32'd9);
        check("beq1_pcwr", 32'(PCWr), 32'd1);
        check("beq1_npc", 32'(NPCsel), 32'd1);
        check("beq1_alu", 32'(ALUop), 32'd1);
        check("beq1_ext", 32'(ExtOp), 32'd1);
        tick();
        check("beq1_fetch", 32'(state), 32'd0);

        // beq not taken
        zero = 1'b0;
        tick();
        tick();
        check("beq0_st", 32'(state), 32'd9);
        check("beq0_pcwr", 32'(PCWr), 32'd0);
        tick();
        check("beq0_fetch", 32'(state), 32'd0);

        // subu
        opcode = 6'b000000;
        funct  = 6'b100011;
        tick();
        check("subu_dec_ill", 32'(illegal), 32'd0);
        tick();
        check("subu_exe_st", 32'(state), 32'd6);
        check("subu_exe_alu", 32'(ALUop), 32'd1);
        check("subu_exe_srcb", 32'(ALUSrcB), 32'd0);
        tick();
        check("subu_rwb_st", 32'(state), 32'd7);
        check("subu_rwb_regwr", 32'(RegWr), 32'd1);
        check("subu_rwb_dst", 32'(RegDst), 32'd1);
        check("subu_rwb_alu", 32'(ALUop), 32'd1);
        tick();
        check("subu_fetch", 32'(state), 32'd0);

        // addu
        funct = 6'b100001;
        tick();
        tick();
        check("addu_exe_alu", 32'(ALUop), 32'd0);
        check("addu_exe_st", 32'(state), 32'd6);
        tick();
        check("addu_rwb_st", 32'(state), 32'd7);
        tick();

        // R-type with unsupported funct
        funct = 6'b000000;
        tick();
        check("ill_dec_st", 32'(state), 32'd1);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_regwr", 32'(RegWr), 32'd0);
        tick();
        check("ill_fetch", 32'(state), 32'd0);
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_regwr2", 32'(RegWr), 32'd0);

        // unsupported opcode
        opcode = 6'b111111;
        tick();
        check("illop_pulse", 32'(illegal), 32'd1);
        tick();
        check("illop_fetch", 32'(state), 32'd0);

        // jr
        opcode = 6'b000000;
        funct  = 6'b001000;
        tick();
        check("jr_dec_ill", 32'(illegal), 32'd0);
        tick();
        check("jr_st", 32'(state), 32'd10);
        check("jr_npc", 32'(NPCsel), 32'd3);
        check("jr_pcwr", 32'(PCWr), 32'd1);
        tick();

        // lui
        opcode = 6'b001111;
        funct  = 6'b000000;
        tick();
        tick();
        check("lui_exe_st", 32'(state), 32'd6);
        check("lui_exe_ext", 32'(ExtOp), 32'd2);
        check("lui_exe_srcb", 32'(ALUSrcB), 32'd1);
        check("lui_exe_alu", 32'(ALUop), 32'd0);
        tick();
        check("lui_iwb_st", 32'(state), 32'd8);
        check("lui_iwb_regwr", 32'(RegWr), 32'd1);
        check("lui_iwb_dst", 32'(RegDst), 32'd0);
        tick();
        check("lui_fetch", 32'(state), 32'd0);

        // sw interrupted by reset in MW
        opcode = 6'b101011;
        tick();
        tick();
        check("sw_ma_st", 32'(state), 32'd2);
        tick();
        check("sw_mw_st", 32'(state), 32'd4);
        check("sw_mw_memwr", 32'(MemWr), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("sw_rst_memwr", 32'(MemWr), 32'd0);
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_irwr", 32'(IRWr), 32'd0);
        tick();
        check("sw_rst_hold", 32'(state), 32'd0);
        check("sw_rst_cyc", cycle_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("sw_rel_irwr", 32'(IRWr), 32'd1);
        tick();
        check("sw_rel_dec", 32'(state), 32'd1);
`ifdef MC_CTRL_PERF_EN
        check("sw_rel_cyc", cycle_cnt, 32'd1);
        check("sw_rel_ins", instr_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
